// File: rtl/val2_shifter_pipe_if.sv
// Operand/result handshake bundle for the Val2 shifter pipe.
// master drives operands and out_ready; slave is the shifter.
interface val2_shifter_pipe_if #(
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] val_rm;
  logic [DATA_W-1:0] val_rs;
  logic [11:0]       shift_operand;
  logic              imm;
  logic              type_signal;
  logic              carry_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] val2;
  logic              carry_out;

  modport master (
    output in_valid, val_rm, val_rs, shift_operand,
    output imm, type_signal, carry_in, out_ready,
    input  in_ready, out_valid, val2, carry_out
  );

  modport slave (
    input  in_valid, val_rm, val_rs, shift_operand,
    input  imm, type_signal, carry_in, out_ready,
    output in_ready, out_valid, val2, carry_out
  );
endinterface

// File: rtl/val2_shifter_pipe.sv
// Pipelined Val2 operand generator: decode to {kind, amount},
// then a log2(W)-level barrel network with ARM carry semantics.
module val2_shifter_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  input logic                flush,
  val2_shifter_pipe_if.slave bus
);
  localparam int AW    = $clog2(DATA_W);
  localparam int AMT_W = AW + 1;
  localparam logic [AMT_W-1:0] A_W  = AMT_W'(DATA_W);
  localparam logic [AMT_W-1:0] A_W1 = AMT_W'(DATA_W + 1);

  localparam logic [2:0] K_PASS = 3'd0;
  localparam logic [2:0] K_LSL  = 3'd1;
  localparam logic [2:0] K_LSR  = 3'd2;
  localparam logic [2:0] K_ASR  = 3'd3;
  localparam logic [2:0] K_ROR  = 3'd4;
  localparam logic [2:0] K_RRX  = 3'd5;

  function automatic logic [DATA_W:0] shr(
    input logic [DATA_W:0]  x,
    input logic [AMT_W-1:0] s,
    input logic             fill
  );
    logic [DATA_W:0] v;
    logic [DATA_W:0] m;
    v = x;
    for (int k = 0; k < AMT_W; k++) begin
      m = ~({(DATA_W+1){1'b1}} >> (1 << k));
      if (s[k]) v = (v >> (1 << k)) | (fill ? m : '0);
    end
    return v;
  endfunction

  function automatic logic [DATA_W:0] shl(
    input logic [DATA_W:0]  x,
    input logic [AMT_W-1:0] s
  );
    logic [DATA_W:0] v;
    v = x;
    for (int k = 0; k < AMT_W; k++)
      if (s[k]) v = v << (1 << k);
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] rotr(
    input logic [DATA_W-1:0] x,
    input logic [AW-1:0]     s
  );
    logic [DATA_W-1:0] v;
    v = x;
    for (int k = 0; k < AW; k++)
      if (s[k])
        v = (v >> (1 << k)) | (v << (DATA_W - (1 << k)));
    return v;
  endfunction

  logic [11:0]       so;
  logic [7:0]        rs8;
  logic [AMT_W-1:0]  ish;
  logic [AMT_W-1:0]  rsa;
  logic [2:0]        dec_kind;
  logic [DATA_W-1:0] dec_data;
  logic [AMT_W-1:0]  dec_amt;
  logic              unused_rs;
  logic              en;

  assign so        = bus.shift_operand;
  assign rs8       = bus.val_rs[7:0];
  assign unused_rs = ^bus.val_rs[DATA_W-1:8];
  assign ish       = AMT_W'(so[11:7]);
  assign rsa       = (rs8 > 8'(DATA_W)) ? A_W1 : AMT_W'(rs8);
  assign en        = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;

  // Every mode is normalised to a kind plus a clamped amount,
  // so the shift stage needs no knowledge of the encoding.
  always_comb begin
    dec_kind = K_PASS;
    dec_data = bus.val_rm;
    dec_amt  = '0;
    if (bus.type_signal) begin
      dec_data = {{(DATA_W-12){so[11]}}, so};
    end else if (bus.imm) begin
      dec_data = DATA_W'(so[7:0]);
      if (so[11:8] != 4'd0) begin
        dec_kind = K_ROR;
        dec_amt  = AMT_W'({so[11:8], 1'b0});
      end
    end else if (!so[4]) begin
      unique case (so[6:5])
        2'b00: if (ish != '0) begin
          dec_kind = K_LSL;
          dec_amt  = ish;
        end
        2'b01: begin
          dec_kind = K_LSR;
          dec_amt  = (ish == '0) ? A_W : ish;
        end
        2'b10: begin
          dec_kind = K_ASR;
          dec_amt  = (ish == '0) ? A_W : ish;
        end
        default: begin
          dec_kind = (ish == '0) ? K_RRX : K_ROR;
          dec_amt  = ish;
        end
      endcase
    end else if (rs8 != 8'd0) begin
      unique case (so[6:5])
        2'b00: begin
          dec_kind = K_LSL;
          dec_amt  = rsa;
        end
        2'b01: begin
          dec_kind = K_LSR;
          dec_amt  = rsa;
        end
        2'b10: begin
          dec_kind = K_ASR;
          dec_amt  = (rs8 >= 8'(DATA_W)) ? A_W : rsa;
        end
        default: begin
          dec_kind = K_ROR;
          dec_amt  = AMT_W'(rs8[AW-1:0]);
        end
      endcase
    end
  end

  logic              x_valid;
  logic [2:0]        x_kind;
  logic [DATA_W-1:0] x_data;
  logic [AMT_W-1:0]  x_amt;
  logic              x_cin;

  generate
    if (STAGES == 2) begin : g_s1
      logic              s1_valid_d, s1_valid_q;
      logic [2:0]        s1_kind_d, s1_kind_q;
      logic [DATA_W-1:0] s1_data_d, s1_data_q;
      logic [AMT_W-1:0]  s1_amt_d, s1_amt_q;
      logic              s1_cin_d, s1_cin_q;

      always_comb begin
        s1_valid_d = s1_valid_q;
        s1_kind_d  = s1_kind_q;
        s1_data_d  = s1_data_q;
        s1_amt_d   = s1_amt_q;
        s1_cin_d   = s1_cin_q;
        if (en) begin
          s1_valid_d = bus.in_valid;
          s1_kind_d  = dec_kind;
          s1_data_d  = dec_data;
          s1_amt_d   = dec_amt;
          s1_cin_d   = bus.carry_in;
        end
        if (flush) s1_valid_d = 1'b0;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_valid_q <= 1'b0;
          s1_kind_q  <= K_PASS;
          s1_data_q  <= '0;
          s1_amt_q   <= '0;
          s1_cin_q   <= 1'b0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_kind_q  <= s1_kind_d;
          s1_data_q  <= s1_data_d;
          s1_amt_q   <= s1_amt_d;
          s1_cin_q   <= s1_cin_d;
        end
      end

      assign x_valid = s1_valid_q;
      assign x_kind  = s1_kind_q;
      assign x_data  = s1_data_q;
      assign x_amt   = s1_amt_q;
      assign x_cin   = s1_cin_q;
    end else begin : g_s1
      assign x_valid = bus.in_valid;
      assign x_kind  = dec_kind;
      assign x_data  = dec_data;
      assign x_amt   = dec_amt;
      assign x_cin   = bus.carry_in;
    end
  endgenerate

  logic [DATA_W-1:0] ex_val;
  logic              ex_c;
  logic [DATA_W:0]   tl;
  logic [DATA_W:0]   tr;

  // The extra bit beside the data word carries the last bit shifted out.
  always_comb begin
    ex_val = x_data;
    ex_c   = x_cin;
    tl     = '0;
    tr     = '0;
    unique case (x_kind)
      K_LSL: begin
        tl     = shl({1'b0, x_data}, x_amt);
        ex_val = tl[DATA_W-1:0];
        ex_c   = tl[DATA_W];
      end
      K_LSR: begin
        tr     = shr({x_data, 1'b0}, x_amt, 1'b0);
        ex_val = tr[DATA_W:1];
        ex_c   = tr[0];
      end
      K_ASR: begin
        tr     = shr({x_data, 1'b0}, x_amt, x_data[DATA_W-1]);
        ex_val = tr[DATA_W:1];
        ex_c   = tr[0];
      end
      K_ROR: begin
        ex_val = rotr(x_data, x_amt[AW-1:0]);
        ex_c   = ex_val[DATA_W-1];
      end
      K_RRX: begin
        ex_val = {x_cin, x_data[DATA_W-1:1]};
        ex_c   = x_data[0];
      end
      default: ;
    endcase
  end

  logic              out_valid_d, out_valid_q;
  logic [DATA_W-1:0] val2_d, val2_q;
  logic              carry_d, carry_q;

  always_comb begin
    out_valid_d = out_valid_q;
    val2_d      = val2_q;
    carry_d     = carry_q;
    if (en) begin
      out_valid_d = x_valid;
      val2_d      = ex_val;
      carry_d     = ex_c;
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      val2_q      <= '0;
      carry_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      val2_q      <= val2_d;
      carry_q     <= carry_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.val2      = val2_q;
  assign bus.carry_out = carry_q;
endmodule
